fft_out_packer: RTL and testbench
=================================

FFT_OUT_PACKER -- requirements
Module: fft_out_packer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port startDrain, input, 1 bit: pulse from the accelerator when calculation is done; begins the drain of the result RAM.
REQ-004 SHALL have port ramRdEn, output, 1 bit: read strobe to the accelerator result RAM.
REQ-005 SHALL have port ramRdAddr, output, 10 bits: sample address, 0..1023.
REQ-006 SHALL have port ramRdData, input, 64 bits: sample {real[31:0], imag[31:0]}, valid exactly 1 cycle after its ramRdEn cycle.
REQ-007 SHALL have port mcDataOut, output, 512 bits: head packed line to the memory controller.
REQ-008 SHALL have port mcDataOutValid, output, 1 bit: mcDataOut holds a valid line.
REQ-009 SHALL have port outFifoReady, output, 1 bit: at least one line is buffered; equal to mcDataOutValid.
REQ-010 SHALL have port accelWrBlkDone, input, 1 bit: MC has consumed the head line (pop).
REQ-011 SHALL have port busy, output, 1 bit: a drain is in progress.
REQ-012 SHALL have port drainDone, output, 1 bit: 1-cycle pulse when the whole result has been consumed.

Function
REQ-013 SHALL use states IDLE and DRAIN; IDLE->DRAIN on startDrain in IDLE; DRAIN->IDLE after the 128th pop.
REQ-014 SHALL ignore startDrain while busy=1.
REQ-015 SHALL, on accepting startDrain, clear the read address, line counter and buffer, and set busy=1 from the next cycle.
REQ-016 SHALL pack 8 consecutive samples per line: sample 8L+k goes to mcDataOut[64k+63:64k], so sample 0 is in the LSBs; 1024 samples make 128 lines.
REQ-017 SHALL hold a 2-entry line buffer plus one assembly register; a line slot is reserved when the first read of a line issues and released on pop.
REQ-018 SHALL issue the first read of a line only while a free slot exists; subsequent reads of that line issue on consecutive cycles, one per cycle; ramRdAddr increments by 1 per issued read.
REQ-019 SHALL commit the assembled line into the buffer in the cycle its 8th sample returns; it is visible as head no earlier than the following cycle.
REQ-020 SHALL issue no reads after address 1023; ramRdEn=0 whenever no read is issued.
REQ-021 SHALL pop the head on a rising edge where accelWrBlkDone=1 and mcDataOutValid=1; accelWrBlkDone with mcDataOutValid=0 is ignored.
REQ-022 SHALL leave occupancy unchanged when a push and a pop happen in the same cycle, and keep lines in FIFO order.
REQ-023 SHALL hold mcDataOut stable while mcDataOutValid=1 and no pop occurs; mcDataOut is don't-care when invalid.
REQ-024 SHALL assert drainDone for exactly 1 cycle, the cycle after the 128th pop, with busy=0 in that same cycle; startDrain in that cycle is accepted.
REQ-025 SHALL reach first mcDataOutValid 10 cycles after the startDrain edge when there is no backpressure: reads in cycles 1-8, data in cycles 2-9, valid from cycle 10.

Reset
REQ-026 SHALL, with rst=1 at any edge including mid-drain, force IDLE, busy=0, drainDone=0, ramRdEn=0, ramRdAddr=0, mcDataOutValid=0, outFifoReady=0, mcDataOut=0, and empty the buffer.
REQ-027 SHALL discard any in-flight ramRdData returning in the cycle after reset.

Verification
REQ-028 SHALL test basic drain: RAM model returns 64-bit zero-extended address; startDrain; MC pops each line immediately -> 128 lines, line L has field k = 8L+k; the first line is valid at cycle 10; exactly one drainDone pulse.
REQ-029 SHALL test backpressure: MC does not pop for 40 cycles -> exactly 16 reads (addresses 0..15) issue and then ramRdEn stays 0; after popping resumes, all data is in order and intact.
REQ-030 SHALL test pop while a line is committing in the same cycle -> occupancy unchanged and no line lost or duplicated.
REQ-031 SHALL test startDrain pulsed mid-drain at line 50 -> ignored, addresses continue monotonically and 128 lines total.
REQ-032 SHALL test rst at line 70 -> all outputs return to reset values the next cycle; a new startDrain restarts from address 0 and line 0.
REQ-033 SHALL test accelWrBlkDone with the buffer empty -> no state change and no underflow.

Source files
------------

// File: rtl/fft_out_packer.sv
// rtl/fft_out_packer.sv - drains the FFT result RAM into 512-bit lines for the memory controller
// Eight 64-bit samples per line; a 2-deep line FIFO with slot reservation bounds outstanding reads.
module fft_out_packer (
    input  logic         clk,
    input  logic         rst,
    input  logic         startDrain,
    output logic         ramRdEn,
    output logic [9:0]   ramRdAddr,
    input  logic [63:0]  ramRdData,
    output logic [511:0] mcDataOut,
    output logic         mcDataOutValid,
    output logic         outFifoReady,
    input  logic         accelWrBlkDone,
    output logic         busy,
    output logic         drainDone
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t         state, state_nxt;
    logic [10:0]    rd_addr;
    logic [1:0]     reserved;
    logic           rd_vld;
    logic [2:0]     ret_cnt;
    logic [447:0]   asm_q;
    logic [511:0]   buf_q [2];
    logic           wr_ptr, rd_ptr;
    logic [1:0]     count;
    logic [7:0]     pop_cnt;
    logic           done_q;

    logic start_acc, pop, push, last_pop, first_rd;

    assign start_acc = (state == IDLE) && startDrain;
    assign pop       = accelWrBlkDone && (count != 2'd0);
    assign push      = rd_vld && (ret_cnt == 3'd7);
    assign last_pop  = pop && (pop_cnt == 8'd127);
    assign first_rd  = ramRdEn && (rd_addr[2:0] == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (startDrain) state_nxt = DRAIN;
            DRAIN:   if (last_pop)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first read of a line needs a free slot; the rest of the line follows back-to-back.
    always_comb begin
        busy    = (state == DRAIN);
        ramRdEn = busy && !rd_addr[10] && ((rd_addr[2:0] != 3'd0) || (reserved != 2'd2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr  <= '0;
            reserved <= '0;
            rd_vld   <= 1'b0;
            ret_cnt  <= '0;
            asm_q    <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            pop_cnt  <= '0;
            done_q   <= 1'b0;
        end else if (start_acc) begin
            rd_addr  <= '0;
            reserved <= '0;
            rd_vld   <= 1'b0;
            ret_cnt  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
            pop_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            rd_vld   <= ramRdEn;
            done_q   <= last_pop;
            reserved <= reserved + 2'(first_rd) - 2'(pop);
            count    <= count + 2'(push) - 2'(pop);
            if (ramRdEn) begin
                rd_addr <= rd_addr + 11'd1;
            end
            if (rd_vld) begin
                ret_cnt <= ret_cnt + 3'd1;
                if (ret_cnt != 3'd7) begin
                    asm_q[{ret_cnt, 6'b0} +: 64] <= ramRdData;
                end
            end
            if (push) begin
                buf_q[wr_ptr] <= {ramRdData, asm_q};
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                pop_cnt <= pop_cnt + 8'd1;
            end
        end
    end

    assign mcDataOut      = buf_q[rd_ptr];
    assign mcDataOutValid = (count != 2'd0);
    assign outFifoReady   = (count != 2'd0);
    assign ramRdAddr      = rd_addr[9:0];
    assign drainDone      = done_q;

endmodule

// File: tb/tb_fft_out_packer.sv
// tb/tb_fft_out_packer.sv - directed, table-driven bench for fft_out_packer
module tb_fft_out_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         startDrain;
    logic         ramRdEn;
    logic [9:0]   ramRdAddr;
    logic [63:0]  ramRdData;
    logic [511:0] mcDataOut;
    logic         mcDataOutValid;
    logic         outFifoReady;
    logic         accelWrBlkDone;
    logic         busy;
    logic         drainDone;

    int errors   = 0;
    int n_checks = 0;
    int next_line;
    int exp_addr = 0;
    int n_reads  = 0;

    fft_out_packer dut (
        .clk            (clk),
        .rst            (rst),
        .startDrain     (startDrain),
        .ramRdEn        (ramRdEn),
        .ramRdAddr      (ramRdAddr),
        .ramRdData      (ramRdData),
        .mcDataOut      (mcDataOut),
        .mcDataOutValid (mcDataOutValid),
        .outFifoReady   (outFifoReady),
        .accelWrBlkDone (accelWrBlkDone),
        .busy           (busy),
        .drainDone      (drainDone)
    );

    always #5 clk = ~clk;

    // RAM model: zero-extended address, one cycle after the read strobe
    always @(posedge clk) begin
        ramRdData <= ramRdEn ? {54'd0, ramRdAddr} : 64'hdeadbeef_deadbeef;
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read-address monitor: addresses must run 0,1,2,... within one drain
    always @(negedge clk) begin
        if (rst) begin
            exp_addr = 0;
            n_reads  = 0;
        end else begin
            if (startDrain && !busy) begin
                exp_addr = 0;
                n_reads  = 0;
            end
            if (ramRdEn) begin
                check("rd_addr", 512'(ramRdAddr), 512'(exp_addr));
                exp_addr++;
                n_reads++;
            end
        end
    end

    function automatic logic [511:0] exp_line(input int l);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[64*k +: 64] = 64'(8 * l + k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_busy",  512'(busy), 512'(0));
        check("rst_done",  512'(drainDone), 512'(0));
        check("rst_rden",  512'(ramRdEn), 512'(0));
        check("rst_addr",  512'(ramRdAddr), 512'(0));
        check("rst_valid", 512'(mcDataOutValid), 512'(0));
        check("rst_ready", 512'(outFifoReady), 512'(0));
        check("rst_data",  mcDataOut, 512'(0));
    endtask

    task automatic pop_check();
        check("pop_valid", 512'(mcDataOutValid), 512'(1));
        check("ready_eq_valid", 512'(outFifoReady), 512'(mcDataOutValid));
        check($sformatf("line%0d", next_line), mcDataOut, exp_line(next_line));
        next_line++;
        accelWrBlkDone = 1'b1;
        tick();
        accelWrBlkDone = 1'b0;
    endtask

    task automatic drain_lines(input int mid_start, input int rst_line);
        int  budget = 0;
        bit  pulsed = 0;
        while (next_line < 128 && budget < 4000) begin
            if (next_line == rst_line) begin
                accelWrBlkDone = 1'b0;
                rst = 1'b1;
                tick();
                check_reset_outputs();
                rst = 1'b0;
                return;
            end
            startDrain = (next_line == mid_start) && !pulsed;
            if (startDrain) pulsed = 1;
            if (mcDataOutValid) begin
                check($sformatf("line%0d", next_line), mcDataOut, exp_line(next_line));
                next_line++;
                accelWrBlkDone = 1'b1;
            end
            tick();
            accelWrBlkDone = 1'b0;
            startDrain = 1'b0;
            budget++;
        end
        check("lines_total", 512'(next_line), 512'(128));
        check("done_pulse",  512'(drainDone), 512'(1));
        check("done_busy",   512'(busy), 512'(0));
        check("reads_total", 512'(n_reads), 512'(1024));
        tick();
        check("done_single", 512'(drainDone), 512'(0));
        check("idle_rden",   512'(ramRdEn), 512'(0));
    endtask

    typedef struct {
        logic       start;
        logic       pop;
        logic       busy;
        logic       rden;
        logic [9:0] addr;
        logic       valid;
    } vec_t;

    vec_t vecs [11];

    initial begin
        // entry i is applied in cycle i (startDrain in cycle 0); expected values are for cycle i+1
        vecs[0]  = '{1, 1, 1, 1, 10'd0,  0};
        vecs[1]  = '{0, 1, 1, 1, 10'd1,  0};
        vecs[2]  = '{0, 1, 1, 1, 10'd2,  0};
        vecs[3]  = '{0, 1, 1, 1, 10'd3,  0};
        vecs[4]  = '{0, 1, 1, 1, 10'd4,  0};
        vecs[5]  = '{0, 1, 1, 1, 10'd5,  0};
        vecs[6]  = '{0, 1, 1, 1, 10'd6,  0};
        vecs[7]  = '{0, 1, 1, 1, 10'd7,  0};
        vecs[8]  = '{0, 0, 1, 1, 10'd8,  0};
        vecs[9]  = '{0, 0, 1, 1, 10'd9,  1};
        vecs[10] = '{0, 0, 1, 1, 10'd10, 1};

        rst = 1'b1;
        startDrain = 1'b0;
        accelWrBlkDone = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        rst = 1'b0;
        tick();

        // basic drain: startup timing from the table, then immediate pops
        next_line = 0;
        for (int i = 0; i < 11; i++) begin
            startDrain     = vecs[i].start;
            accelWrBlkDone = vecs[i].pop;
            tick();
            startDrain     = 1'b0;
            accelWrBlkDone = 1'b0;
            check($sformatf("v%0d_busy", i),  512'(busy), 512'(vecs[i].busy));
            check($sformatf("v%0d_rden", i),  512'(ramRdEn), 512'(vecs[i].rden));
            check($sformatf("v%0d_addr", i),  512'(ramRdAddr), 512'(vecs[i].addr));
            check($sformatf("v%0d_valid", i), 512'(mcDataOutValid), 512'(vecs[i].valid));
        end
        drain_lines(-1, -1);

        // pops while idle and empty
        for (int i = 0; i < 3; i++) begin
            accelWrBlkDone = 1'b1;
            tick();
            check("empty_pop_valid", 512'(mcDataOutValid), 512'(0));
            check("empty_pop_busy",  512'(busy), 512'(0));
        end
        accelWrBlkDone = 1'b0;

        // backpressure, then a pop coinciding with a line commit
        next_line = 0;
        startDrain = 1'b1;
        tick();
        startDrain = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("bp_reads", 512'(n_reads), 512'(16));
        check("bp_rden",  512'(ramRdEn), 512'(0));
        pop_check();
        for (int i = 0; i < 8; i++) tick();
        pop_check();
        pop_check();
        check("commit_pop_empty", 512'(mcDataOutValid), 512'(0));
        drain_lines(-1, -1);

        // startDrain mid-drain is ignored
        next_line = 0;
        startDrain = 1'b1;
        tick();
        startDrain = 1'b0;
        drain_lines(50, -1);

        // reset at line 70, then restart from scratch
        next_line = 0;
        startDrain = 1'b1;
        tick();
        startDrain = 1'b0;
        drain_lines(-1, 70);
        tick();
        check_reset_outputs();
        next_line = 0;
        startDrain = 1'b1;
        tick();
        startDrain = 1'b0;
        check("restart_addr", 512'(ramRdAddr), 512'(0));
        drain_lines(-1, -1);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
